// File: rtl/keyrom_reader.sv
`default_nettype none
// ============================================================================
// Module  : keyrom_reader
// Brief   : Fetches KEY_WORDS words from the secure key ROM and streams them
//           in address order over a valid/ready interface, wiping each word
//           once consumed.
// Revision: 1.0
// ============================================================================
module keyrom_reader #(
    parameter int ADDR_MSB  = 4,
    parameter int MEM_SIZE  = 20,
    parameter int BASE_ADDR = 0,
    parameter int KEY_WORDS = 4
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_MSB:0] rom_addr,
    output logic              rom_cen,
    input  logic [15:0]       rom_dout,
    output logic [15:0]       key_data,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_last,
    output logic              busy,
    output logic              done
);

    localparam int c_AW   = ADDR_MSB + 1;
    localparam int c_IDXW = $clog2(KEY_WORDS) + 1;

    localparam logic [c_AW-1:0]   c_BASE     = c_AW'(BASE_ADDR);
    localparam logic [c_IDXW-1:0] c_LAST_IDX = c_IDXW'(KEY_WORDS - 1);
    localparam logic [c_IDXW-1:0] c_IDX_ONE  = c_IDXW'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_CAPT = 2'd2;
    localparam logic [1:0] c_HOLD = 2'd3;

    generate
        if ((KEY_WORDS < 1) || (BASE_ADDR + KEY_WORDS > MEM_SIZE / 2)) begin : g_bad_range
            $error("keyrom_reader: BASE_ADDR+KEY_WORDS must fit within MEM_SIZE/2 words");
        end
    endgenerate

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_IDXW-1:0] r_index;
    logic [c_IDXW-1:0] w_index_nxt;
    logic [c_IDXW-1:0] w_index_inc;
    logic [c_AW-1:0]   r_rom_addr;
    logic [c_AW-1:0]   w_rom_addr_nxt;
    logic              r_rom_cen;
    logic              w_rom_cen_nxt;
    logic [15:0]       r_key_data;
    logic [15:0]       w_key_data_nxt;
    logic              r_key_valid;
    logic              w_key_valid_nxt;
    logic              r_key_last;
    logic              w_key_last_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;

    logic              w_handshake;
    logic              w_abort;

    assign w_handshake = r_key_valid & key_ready;
    assign w_abort     = abort & (r_state != c_IDLE);
    assign w_index_inc = r_index + c_IDX_ONE;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_IDLE;
            r_index     <= '0;
            r_rom_addr  <= '0;
            r_rom_cen   <= 1'b1;
            r_key_data  <= '0;
            r_key_valid <= 1'b0;
            r_key_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_index     <= w_index_nxt;
            r_rom_addr  <= w_rom_addr_nxt;
            r_rom_cen   <= w_rom_cen_nxt;
            r_key_data  <= w_key_data_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_last  <= w_key_last_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  if (start) w_state_nxt = c_REQ;
                c_REQ:   w_state_nxt = c_CAPT;
                c_CAPT:  w_state_nxt = c_HOLD;
                c_HOLD:  if (w_handshake) w_state_nxt = r_key_last ? c_IDLE : c_REQ;
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    // Registered outputs are computed one cycle early so rom_cen is low
    // exactly while the FSM sits in REQ.
    always_comb begin
        w_index_nxt     = r_index;
        w_rom_addr_nxt  = r_rom_addr;
        w_rom_cen_nxt   = 1'b1;
        w_key_data_nxt  = r_key_data;
        w_key_valid_nxt = r_key_valid;
        w_key_last_nxt  = r_key_last;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        if (w_abort) begin
            w_index_nxt     = '0;
            w_key_data_nxt  = '0;
            w_key_valid_nxt = 1'b0;
            w_key_last_nxt  = 1'b0;
            w_busy_nxt      = 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        w_index_nxt    = '0;
                        w_busy_nxt     = 1'b1;
                        w_rom_cen_nxt  = 1'b0;
                        w_rom_addr_nxt = c_BASE;
                    end
                end
                c_CAPT: begin
                    w_key_data_nxt  = rom_dout;
                    w_key_valid_nxt = 1'b1;
                    w_key_last_nxt  = (r_index == c_LAST_IDX);
                end
                c_HOLD: begin
                    if (w_handshake) begin
                        w_key_data_nxt  = '0;
                        w_key_valid_nxt = 1'b0;
                        w_key_last_nxt  = 1'b0;
                        if (r_key_last) begin
                            w_index_nxt = '0;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_index_nxt    = w_index_inc;
                            w_rom_cen_nxt  = 1'b0;
                            w_rom_addr_nxt = c_BASE + c_AW'(w_index_inc);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rom_addr  = r_rom_addr;
    assign rom_cen   = r_rom_cen;
    assign key_data  = r_key_data;
    assign key_valid = r_key_valid;
    assign key_last  = r_key_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_keyrom_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_keyrom_reader
// Brief   : Self-checking bench for keyrom_reader against a word-sequence model.
// Revision: 1.0
// ============================================================================
module tb_keyrom_reader;

    localparam int c_KW    = 4;
    localparam int c_BASE1 = 6;

    logic        mclk = 1'b0;
    logic        reset_n;
    always #5 mclk = ~mclk;

    logic        start, abort, key_ready;
    logic [4:0]  rom_addr;
    logic        rom_cen;
    logic [15:0] rom_dout;
    logic [15:0] key_data;
    logic        key_valid, key_last, busy, done;

    logic        start1, abort1, key_ready1;
    logic [4:0]  rom_addr1;
    logic        rom_cen1;
    logic [15:0] rom_dout1;
    logic [15:0] key_data1;
    logic        key_valid1, key_last1, busy1, done1;

    logic [15:0] rom_mem [0:9];
    int          addr_q[$];
    int          addr_q1[$];
    int          checks;
    int          errors;

    keyrom_reader #(.ADDR_MSB(4), .MEM_SIZE(20), .BASE_ADDR(0), .KEY_WORDS(c_KW)) dut (
        .mclk(mclk), .reset_n(reset_n), .start(start), .abort(abort),
        .rom_addr(rom_addr), .rom_cen(rom_cen), .rom_dout(rom_dout),
        .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
        .key_last(key_last), .busy(busy), .done(done)
    );

    keyrom_reader #(.ADDR_MSB(4), .MEM_SIZE(20), .BASE_ADDR(c_BASE1), .KEY_WORDS(c_KW)) dut1 (
        .mclk(mclk), .reset_n(reset_n), .start(start1), .abort(abort1),
        .rom_addr(rom_addr1), .rom_cen(rom_cen1), .rom_dout(rom_dout1),
        .key_data(key_data1), .key_valid(key_valid1), .key_ready(key_ready1),
        .key_last(key_last1), .busy(busy1), .done(done1)
    );

    // Synchronous ROMs; every enabled read address is logged.
    always @(posedge mclk) begin
        if (!rom_cen) begin
            rom_dout <= rom_mem[rom_addr];
            addr_q.push_back(int'(rom_addr));
        end
        if (!rom_cen1) begin
            rom_dout1 <= rom_mem[rom_addr1];
            addr_q1.push_back(int'(rom_addr1));
        end
    end

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_data"},  32'(key_data),  32'h0);
        chk({tag, "_valid"}, 32'(key_valid), 32'h0);
        chk({tag, "_last"},  32'(key_last),  32'h0);
        chk({tag, "_busy"},  32'(busy),      32'h0);
        chk({tag, "_done"},  32'(done),      32'h0);
        chk({tag, "_cen"},   32'(rom_cen),   32'h1);
    endtask

    // mode 0: ready always high, 1: random ready, 2: 10-cycle stall on first word.
    task automatic do_fetch(input int mode, input int abort_after);
        int          n, cyc, stall, ndone;
        bit          hs, prev_hs, prev_stall, aborted;
        logic [15:0] prev_data;
        addr_q.delete();
        n = 0; cyc = 0; stall = 0; ndone = 0;
        prev_hs = 1'b0; prev_stall = 1'b0; aborted = 1'b0; prev_data = '0;
        key_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (ndone == 0 && cyc < 300) begin
            if (prev_hs) begin
                chk("wipe_valid", 32'(key_valid), 32'h0);
                chk("wipe_data",  32'(key_data),  32'h0);
                chk("wipe_last",  32'(key_last),  32'h0);
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(key_valid), 32'h1);
                chk("stall_data",  32'(key_data),  32'(prev_data));
            end
            if (key_valid) chk("cen_in_hold", 32'(rom_cen), 32'h1);
            chk("busy", 32'(busy), 32'(n < c_KW));
            if (done) begin
                ndone++;
                start = 1'b0;
                chk("done_words", 32'(n), 32'(c_KW));
                if (mode == 0) chk("done_latency", 32'(cyc), 32'd12);
            end else if (abort_after != 0 && prev_hs && n == abort_after) begin
                abort = 1'b1;
                start = 1'b1;
                tick();
                abort = 1'b0;
                start = 1'b0;
                chk_idle("abort");
                tick();
                chk("abort_nodone", 32'(done), 32'h0);
                chk("abort_idle",   32'(busy), 32'h0);
                chk("abort_reads",  32'(addr_q.size()), 32'(abort_after + 1));
                aborted = 1'b1;
                break;
            end else begin
                case (mode)
                    1:       key_ready = 1'($urandom_range(0, 1));
                    2:       key_ready = (stall >= 10);
                    default: key_ready = 1'b1;
                endcase
                if (key_valid && !key_ready) stall++;
                start = ($urandom_range(0, 3) == 0);
                hs = key_valid && key_ready;
                if (hs) begin
                    chk("word_data", 32'(key_data), 32'(rom_mem[n]));
                    chk("word_last", 32'(key_last), 32'(n == c_KW - 1));
                    n++;
                end
                prev_stall = key_valid && !key_ready;
                prev_hs    = hs;
                prev_data  = key_data;
                tick();
                cyc++;
            end
        end
        if (!aborted) begin
            chk("done_seen", 32'(ndone), 32'h1);
            tick();
            chk("done_pulse", 32'(done), 32'h0);
            repeat (3) tick();
            chk_idle("post");
            chk("read_count", 32'(addr_q.size()), 32'(c_KW));
            foreach (addr_q[i]) chk("read_addr", 32'(addr_q[i]), 32'(i));
        end
    endtask

    initial begin
        int n1;
        bit prev1, got1;
        checks = 0; errors = 0;
        start = 1'b0; abort = 1'b0; key_ready = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; key_ready1 = 1'b1;
        for (int i = 0; i < 10; i++) rom_mem[i] = 16'($urandom);
        rom_mem[0] = 16'h0123; rom_mem[1] = 16'h4567;
        rom_mem[2] = 16'h89ab; rom_mem[3] = 16'hcdef;

        reset_n = 1'b0;
        repeat (3) tick();
        chk_idle("reset");
        chk("reset_addr", 32'(rom_addr), 32'h0);
        reset_n = 1'b1;
        repeat (2) tick();
        chk_idle("idle");

        do_fetch(0, 0);
        do_fetch(2, 0);
        for (int i = 0; i < 10; i++) rom_mem[i] = 16'($urandom);
        do_fetch(1, 0);
        do_fetch(1, 0);
        do_fetch(0, 2);
        do_fetch(0, 0);

        // Asynchronous reset while a word is held un-consumed.
        key_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10 && !key_valid; c++) tick();
        chk("hold_before_reset", 32'(key_valid), 32'h1);
        #3 reset_n = 1'b0;
        #1;
        chk_idle("async_rst");
        #3 reset_n = 1'b1;
        repeat (3) tick();
        chk_idle("after_rst");

        // Offset instance: words come from ROM[6..9].
        addr_q1.delete();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n1 = 0; prev1 = 1'b0; got1 = 1'b0;
        for (int c = 0; c < 60 && !got1; c++) begin
            if (prev1) chk("b6_wipe", 32'(key_data1), 32'h0);
            if (done1) begin
                got1 = 1'b1;
                chk("b6_words", 32'(n1), 32'(c_KW));
            end else begin
                prev1 = key_valid1;
                if (key_valid1) begin
                    chk("b6_data", 32'(key_data1), 32'(rom_mem[c_BASE1 + n1]));
                    chk("b6_last", 32'(key_last1), 32'(n1 == c_KW - 1));
                    n1++;
                end
                tick();
            end
        end
        chk("b6_done_seen", 32'(got1), 32'h1);
        chk("b6_reads", 32'(addr_q1.size()), 32'(c_KW));
        foreach (addr_q1[i]) chk("b6_addr", 32'(addr_q1[i]), 32'(c_BASE1 + i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
